// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder issuing byte/word accesses and returning write-back data
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [5:0]  op,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lane;
  logic        byte_q, rd_q, m2r_q;
  logic        is_byte, legal;
  logic [7:0]  rbyte;
  assign is_byte   = (op == 6'd10) || (op == 6'd12);
  assign legal     = is_byte || (alu_result[1:0] == 2'b00);
  assign rbyte     = dmem_rdata[{lane, 3'b000} +: 8];
  assign busy      = (state != IDLE);
  assign ready_out = !busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lane       <= '0;
      byte_q     <= 1'b0;
      rd_q       <= 1'b0;
      m2r_q      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      err        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          lane   <= alu_result[1:0];
          byte_q <= is_byte;
          rd_q   <= mem_read && !mem_write;
          m2r_q  <= mem_to_reg;
          if (!(mem_read || mem_write)) begin
            state    <= DONE;
            wb_data  <= alu_result;
            wb_valid <= 1'b1;
          end else if (!legal) begin
            state <= DONE;
            err   <= 1'b1;
          end else begin
            state      <= ACCESS;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_be    <= is_byte ? 4'b0001 << alu_result[1:0] : 4'b1111;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= is_byte ? {4{store_data[7:0]}} : store_data;
          end
        end
        ACCESS: if (dmem_ack) begin
          state    <= DONE;
          dmem_req <= 1'b0;
          if (rd_q) begin
            wb_data  <= byte_q ? {24'd0, rbyte} : dmem_rdata;
            wb_valid <= m2r_q;
          end
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state    <= DONE;
          dmem_req <= 1'b0;
          err      <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 0, rst = 1, valid_in = 0;
  logic [5:0]  op = 0;
  logic        mem_read = 0, mem_write = 0, mem_to_reg = 0;
  logic [31:0] alu_result = 0, store_data = 0, dmem_rdata = 0;
  logic        dmem_ack = 0;
  logic        ready_out, dmem_req, dmem_we, wb_valid, busy, err;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  typedef struct {int kind; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, t0, n;
  logic prev_req = 0;
  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .op(op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_result(alu_result), .store_data(store_data), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction
  function automatic void push(int k, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] d);
    exp_t e;
    e.kind = k; e.we = w; e.be = b; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction
  // kind 0 = bus request, 1 = write-back, 2 = error pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dmem_req && !prev_req) begin
        if (sb.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          e = sb.pop_front();
          chk("req_kind", 0, e.kind);
          chk("req_we", dmem_we, e.we);
          chk("req_be", dmem_be, e.be);
          chk("req_addr", dmem_addr, e.addr);
          chk("req_wdata", dmem_wdata, e.data);
        end
      end
      if (wb_valid) begin
        if (sb.size() == 0) chk("unexpected_wb", wb_data, 32'hx);
        else begin
          e = sb.pop_front();
          chk("wb_kind", 1, e.kind);
          chk("wb_data", wb_data, e.data);
        end
      end
      if (err) begin
        if (sb.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = sb.pop_front();
          chk("err_kind", 2, e.kind);
        end
      end
    end
    prev_req = dmem_req;
  end
  task automatic send(input logic [5:0] o, input logic r, input logic w, input logic m,
                      input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    @(negedge clk);
    while (!ready_out && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("accept_timeout", 0, 1);
    op = o; mem_read = r; mem_write = w; mem_to_reg = m; alu_result = a; store_data = d;
    valid_in = 1;
    @(posedge clk);
    #1 valid_in = 0;
    t0 = cyc;
  endtask
  task automatic mem_ack(input int delay, input logic [31:0] rd);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    chk("req_before_ack", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = rd;
    @(posedge clk);
    #1 dmem_ack = 0;
    chk("req_fall", dmem_req, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb", {wb_valid, err}, 0);
    chk("rst_wbdata", wb_data, 0);
    rst = 0;
    push(0, 0, 4'b1111, 32'h100, 32'h0);
    push(1, 0, 0, 0, 32'hDEADBEEF);
    send(6'd11, 1, 0, 1, 32'h100, 32'h0);
    mem_ack(3, 32'hDEADBEEF);
    chk("ldw_wb_pulse", wb_valid, 1);
    push(0, 0, 4'b1000, 32'h200, 32'h0);
    push(1, 0, 0, 0, 32'h000000AA);
    send(6'd10, 1, 0, 1, 32'h203, 32'h0);
    mem_ack(0, 32'hAABBCCDD);
    chk("lbd_wb_data", wb_data, 32'hAA);
    push(0, 1, 4'b0010, 32'h300, 32'h77777777);
    send(6'd12, 0, 1, 0, 32'h301, 32'h12345677);
    mem_ack(1, 32'h0);
    chk("stb_no_wb", wb_valid, 0);
    push(2, 0, 0, 0, 0);
    send(6'd13, 0, 1, 0, 32'h402, 32'hCAFEF00D);
    chk("mis_err", err, 1);
    chk("mis_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("mis_ready", ready_out, 1);
    chk("mis_err_fall", err, 0);
    push(0, 0, 4'b1111, 32'h500, 32'h0);
    push(2, 0, 0, 0, 0);
    send(6'd11, 1, 0, 1, 32'h500, 32'h0);
    n = 0;
    while (dmem_req && n < 20) begin n++; @(posedge clk); #1; end
    chk("to_req_cycles", n, 4);
    chk("to_err", err, 1);
    @(negedge clk); dmem_ack = 1; dmem_rdata = 32'h55555555;
    repeat (2) @(posedge clk);
    #1 dmem_ack = 0;
    chk("late_ack_wb", wb_valid, 0);
    chk("late_ack_busy", busy, 0);
    push(1, 0, 0, 0, 32'h7);
    send(6'd0, 0, 0, 0, 32'h7, 32'h0);
    chk("add_wb_pulse", wb_valid, 1);
    n = t0;
    push(1, 0, 0, 0, 32'h9);
    send(6'd0, 0, 0, 0, 32'h9, 32'h0);
    chk("add_throughput", t0 - n, 2);
    push(0, 0, 4'b1111, 32'h600, 32'h0);
    push(1, 0, 0, 0, 32'h11223344);
    send(6'd11, 1, 0, 1, 32'h600, 32'h0);
    @(negedge clk);
    op = 6'd0; mem_read = 0; mem_write = 0; alu_result = 32'h55; valid_in = 1;
    @(negedge clk);
    chk("busy_hold", busy, 1);
    valid_in = 0;
    mem_ack(0, 32'h11223344);
    @(posedge clk); #1;
    chk("ignored_idle", busy, 0);
    push(0, 1, 4'b1111, 32'h700, 32'hA5A5A5A5);
    send(6'd14, 0, 1, 0, 32'h700, 32'hA5A5A5A5);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_mid_req", dmem_req, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_wb", {wb_valid, err}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage responder for the control unit's memory signals. Accepts one decoded instruction at a time (opcode, `mem_read`/`mem_write`/`mem_to_reg`, ALU result and store data) and performs the byte or word access on the data-memory request/acknowledge bus. It returns a write-back value to the register file and stalls upstream while an access is outstanding. It sits between the ALU and the register-file write port.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `dmem_ack` before aborting the access (1..255).
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid_in` input 1: an instruction is presented this cycle.
- `ready_out` output 1: unit can accept; equals `!busy`.
- `op` input 6: opcode. 10 = LBD (load byte), 11 = LDW (load word), 12 = STB (store byte), 13 = STW (store word), 14 = MOV (treated as a word store).
- `mem_read`, `mem_write`, `mem_to_reg` input 1 each: control-unit outputs for this instruction.
- `alu_result` input 32: effective address for memory ops; pass-through value otherwise.
- `store_data` input 32: data for stores.
- `dmem_req` output 1: request strobe, held until acknowledged.
- `dmem_we` output 1: 1 = write.
- `dmem_be` output 4: byte enables; bit i selects bits [8i+7:8i].
- `dmem_addr` output 32: word-aligned address (`alu_result` with [1:0] forced to 00).
- `dmem_wdata` output 32: write data, lane-replicated for bytes.
- `dmem_ack` input 1: memory has completed the request.
- `dmem_rdata` input 32: read data, valid when `dmem_ack` = 1.
- `wb_valid` output 1: one-cycle pulse when a write-back result is available.
- `wb_data` output 32: write-back value.
- `busy` output 1: an instruction is in flight.
- `err` output 1: one-cycle pulse on a misaligned word access or a timeout.

## Operation
- States: IDLE, ACCESS, DONE. `busy` = (state != IDLE).
- **IDLE, `valid_in`=1:** capture all inputs.
  - If `mem_read`=1 or `mem_write`=1 and the access is legal, go to ACCESS.
  - If neither is set, go to DONE with `wb_data`=`alu_result`.
- **Legal access:**
  - Byte ops (10, 12): any address.
  - Word ops (11, 13, 14): `alu_result[1:0]`=00.
  - A misaligned word op goes to DONE with `err` asserted, no bus request and no write-back.
- **`mem_read` and `mem_write` both set:** treated as a write.
- **`dmem_be`:**
  - Word: 1111.
  - Byte: one-hot `1 << alu_result[1:0]`.
- **`dmem_wdata`:**
  - Word: `store_data`.
  - Byte: `{4{store_data[7:0]}}`.
- **ACCESS:**
  - `dmem_req`=1 and all `dmem_*` outputs are stable until `dmem_ack`.
  - On `dmem_ack`, latch the result and go to DONE.
  - Byte loads are zero-extended from lane `alu_result[1:0]` of `dmem_rdata`.
- **Timeout counter (8-bit):** cleared on entry to ACCESS and incremented each ACCESS cycle without ack. When it reaches `TIMEOUT`, go to DONE with `err` asserted and no write-back.
- **DONE** lasts one cycle, then returns to IDLE.
  - `wb_valid`=1 only for loads with `mem_to_reg`=1 and for non-memory ops.
  - Stores never assert `wb_valid`.
- `valid_in` while `busy` is ignored. Upstream must hold the instruction until `ready_out`.

## Timing
- **Reset values:**
  - State IDLE and counter 0.
  - `dmem_req`, `dmem_we`, `wb_valid`, `err`, `busy` = 0; `ready_out` = 1.
  - `dmem_be` = 0000; `dmem_addr`, `dmem_wdata`, `wb_data` = 0.
- Accept on edge N (`valid_in` & `ready_out`). `dmem_req` rises after edge N.
- **Ack rules:**
  - `dmem_ack` is sampled only while `dmem_req`=1. An ack in the first request cycle is legal, giving a minimum memory latency of 1 cycle.
  - If the ack arrives during cycle N+k, `dmem_req` falls and `wb_valid`/`err` pulse during cycle N+k+1. `ready_out` returns during cycle N+k+2.
- Non-memory op: `wb_valid` during cycle N+1. Throughput is one instruction per 2 cycles.
- Misaligned op: `err` during cycle N+1, with no `dmem_req` at any time.
- Timeout: `dmem_req` is held for exactly `TIMEOUT` cycles, then drops; `err` pulses the following cycle.
- A late ack (after the timeout drop) is ignored.
- Reset mid-ACCESS: `dmem_req` drops immediately (asynchronously), with no `wb_valid` or `err`.

## Test plan
- LDW, `alu_result`=0x100, memory acks 3 cycles after the request with 0xDEADBEEF -> `dmem_be`=1111, `dmem_addr`=0x100, `dmem_we`=0, `wb_valid` with `wb_data`=0xDEADBEEF one cycle after the ack.
- LBD, `alu_result`=0x203, `dmem_rdata`=0xAABBCCDD -> `dmem_be`=1000, `dmem_addr`=0x200, `wb_data`=0x000000AA.
- STB, `alu_result`=0x301, `store_data`=0x12345677 -> `dmem_we`=1, `dmem_be`=0010, `dmem_wdata`=0x77777777, no `wb_valid`.
- STW to 0x402 -> `err` pulse at N+1, `dmem_req` never asserted, `ready_out` restored at N+2.
- `TIMEOUT`=4 and memory never acks -> `dmem_req` high for exactly 4 cycles, then an `err` pulse; an ack injected afterwards has no effect.
- ADD (op 0, `mem_to_reg`=0, `alu_result`=7) -> `wb_data`=7 with `wb_valid` at N+1. Also: `rst` asserted mid-ACCESS clears `dmem_req` at once, and `valid_in` while busy is ignored.
